wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage of the two-slot VLIW pipeline. It sits directly downstream of the MEM stage and its MEM/WB pipeline register, and consumes the p4_* bundle.
- It owns the 8x32 architectural register file, with one write port per slot (ALU slot, MEM slot), and the ZNCV flag register.
- It provides four combinational read ports with same-cycle write bypass to the decode stage, and flags conflicting slot writes.

Parameters:
NUM_REGS, 8, register-file depth; address width is fixed at 3 bits.
DATA_W, 32, register and datapath width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
p4_alu_we  input  1  ALU slot has a valid register write this cycle.
p4_alu_rd  input  3  ALU slot destination register.
p4_alu_aluOut  input  32  ALU slot result.
p4_mem_we  input  1  MEM slot has a valid load writeback this cycle.
p4_mem_rd  input  3  MEM slot destination register.
p4_mem_memOut  input  32  raw load data from MEM stage.
p4_mem_byte  input  1  1 = byte load: write {24'b0, memOut[7:0]}; 0 = full word.
p4_flag_we  input  1  update flag register this cycle.
p4_flag_z / p4_flag_n / p4_flag_c / p4_flag_v  input  1 each  new flag values.
id_rs0 / id_rs1 / id_rs2 / id_rs3  input  3 each  decode read addresses (slot A: rs0/rs1; slot B: rs2/rs3).
id_rdata0 / id_rdata1 / id_rdata2 / id_rdata3  output  32 each  read data for the matching id_rs*.
flags_out  output  4  registered {z,n,c,v}.
wb_conflict  output  1  registered one-cycle pulse: both slots targeted the same nonzero rd.
retire_cnt  output  32  retired-write counter (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-high: regs r1..r7 = 0, flags_out = 4'b0, wb_conflict = 0, retire_cnt = 0.
- Asserting reset mid-cycle clears state immediately. Any write presented in a cycle where reset is high is discarded.
- r0 is hardwired zero:
  - writes to r0 are ignored;
  - reads of r0 return 0;
  - writes to r0 never raise wb_conflict.
- Write data:
  - ALU slot writes p4_alu_aluOut.
  - MEM slot writes the load-formatted value: byte zero-extension when p4_mem_byte = 1, otherwise the full word.
- Write latency: data is written at the rising edge ending the cycle in which the corresponding *_we is high. The value appears in the register array from the next cycle.
- Read ports are purely combinational, with bypass priority:
  1. addr == 0 → 0;
  2. p4_mem_we and p4_mem_rd == addr → MEM write data;
  3. p4_alu_we and p4_alu_rd == addr → ALU write data;
  4. otherwise the array contents.
- Same-rd conflict (both we = 1, p4_alu_rd == p4_mem_rd != 0):
  - the MEM slot value is written and the ALU value is dropped;
  - wb_conflict = 1 in the following cycle only, then returns to 0 unless the conflict repeats;
  - back-to-back conflicts hold wb_conflict high continuously.
- Different rd: both slots write in the same edge.
- Flags:
  - flags_out loads {z,n,c,v} at the edge when p4_flag_we = 1, otherwise it holds;
  - no bypass, so decode sees new flags one cycle after the write.
- No handshake or stall: the stage accepts one bundle per cycle unconditionally.

Optional Feature:
Macro: WB_RETIRE_CNT_EN
- Defined:
  - retire_cnt increments each edge by p4_alu_we + p4_mem_we (0, 1 or 2);
  - r0-targeted and conflict-dropped writes still count;
  - the counter wraps modulo 2^32 (0xFFFFFFFF + 2 → 0x00000001);
  - reset clears it.
- Undefined: the counter logic is omitted and retire_cnt is tied to 32'h0. The port stays present, so the interface is identical.

Test Plan:
- Reset, then read all ports with id_rs* = 0..7 → every id_rdata* = 0, flags_out = 0, wb_conflict = 0.
- alu_we = 1, rd = 3, aluOut = 0xDEADBEEF; id_rs0 = 3 in the same cycle → id_rdata0 = 0xDEADBEEF (bypass). Next cycle with we = 0 → still 0xDEADBEEF.
- mem_we = 1, rd = 5, memOut = 0x123456A7, byte = 1 → r5 = 0x000000A7. Repeat with byte = 0 → r5 = 0x123456A7.
- Both we = 1, rd = 2, alu = 0x11, mem = 0x22 → r2 = 0x22 and wb_conflict = 1 for exactly one cycle. Same stimulus with rd = 0 → r0 reads 0 and wb_conflict stays 0.
- flag_we = 1 with z = 1, c = 1 → flags_out = 4'b1010 next cycle. Then flag_we = 0 with inputs 4'b0101 → flags_out holds 4'b1010.
- With WB_RETIRE_CNT_EN: preload the counter near wrap by issuing writes, then apply both we = 1 at 0xFFFFFFFF → 0x00000001. Assert reset mid-burst → 0 immediately. Without the macro → retire_cnt = 0 throughout.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: two-slot VLIW writeback with 8x32 register file, ZNCV flags and 4 bypassed read ports.
// Optional retired-write counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p4_alu_we,
  input  logic [2:0]        p4_alu_rd,
  input  logic [DATA_W-1:0] p4_alu_aluOut,
  input  logic              p4_mem_we,
  input  logic [2:0]        p4_mem_rd,
  input  logic [DATA_W-1:0] p4_mem_memOut,
  input  logic              p4_mem_byte,
  input  logic              p4_flag_we,
  input  logic              p4_flag_z,
  input  logic              p4_flag_n,
  input  logic              p4_flag_c,
  input  logic              p4_flag_v,
  input  logic [2:0]        id_rs0,
  input  logic [2:0]        id_rs1,
  input  logic [2:0]        id_rs2,
  input  logic [2:0]        id_rs3,
  output logic [DATA_W-1:0] id_rdata0,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [DATA_W-1:0] id_rdata3,
  output logic [3:0]        flags_out,
  output logic              wb_conflict,
  output logic [31:0]       retire_cnt
);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [3:0]        r_flags;
  logic              r_conflict;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_conflict;
  logic [2:0]        w_rs [4];
  logic [DATA_W-1:0] w_rdata [4];
  assign w_mem_data = p4_mem_byte ? {{(DATA_W-8){1'b0}}, p4_mem_memOut[7:0]} : p4_mem_memOut;
  assign w_conflict = p4_alu_we && p4_mem_we && p4_alu_rd == p4_mem_rd && p4_mem_rd != 3'd0;
  assign w_rs = '{id_rs0, id_rs1, id_rs2, id_rs3};
  // MEM bypass outranks ALU so reads agree with what a conflicting edge will store
  for (genvar g = 0; g < 4; g++) begin : g_rd
    assign w_rdata[g] = w_rs[g] == 3'd0 ? '0 :
                        (p4_mem_we && p4_mem_rd == w_rs[g]) ? w_mem_data :
                        (p4_alu_we && p4_alu_rd == w_rs[g]) ? p4_alu_aluOut :
                        r_regs[w_rs[g]];
  end
  assign id_rdata0   = w_rdata[0];
  assign id_rdata1   = w_rdata[1];
  assign id_rdata2   = w_rdata[2];
  assign id_rdata3   = w_rdata[3];
  assign flags_out   = r_flags;
  assign wb_conflict = r_conflict;
  // The MEM write comes last so it overrides the ALU write on a shared rd
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_flags    <= 4'b0;
      r_conflict <= 1'b0;
    end else begin
      if (p4_alu_we && p4_alu_rd != 3'd0) r_regs[p4_alu_rd] <= p4_alu_aluOut;
      if (p4_mem_we && p4_mem_rd != 3'd0) r_regs[p4_mem_rd] <= w_mem_data;
      if (p4_flag_we) r_flags <= {p4_flag_z, p4_flag_n, p4_flag_c, p4_flag_v};
      r_conflict <= w_conflict;
    end
  end
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_retire <= 32'h0;
    else r_retire <= r_retire + 32'(p4_alu_we) + 32'(p4_mem_we);
  end
  assign retire_cnt = r_retire;
`else
  assign retire_cnt = 32'h0;
`endif
endmodule
